// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Holds the FSM encoding, vector count and the settle-counter width helper.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;
    localparam int ERR_W       = 3;

    // Counter width able to hold SETTLE_CYCLES-2, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Down-counter that paces how long each test vector is held on the gate.
// Latency: tc is asserted the cycle the count reaches zero; no backpressure.
// Load takes priority over decrement; count holds at zero once there.
module settle_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Drives all four {a,b} vectors into a 2-input gate and compares out against a golden table.
// Latency: done pulses 4*SETTLE_CYCLES edges after start is accepted; start is ignored while busy.
// Results (pass, fail_mask, err_count) hold until the next accepted start.
module gate_tt_checker
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL =
        CNT_W'((SETTLE_CYCLES > 1) ? (SETTLE_CYCLES - 2) : 0);
    // The CHECK state itself accounts for the final settle cycle.
    localparam state_t FIRST_ST = (SETTLE_CYCLES == 1) ? CHECK : SETTLE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         exp_q;
    logic [ERR_W-1:0]   err_next;
    logic               accept;
    logic               check;
    logic               last_vec;
    logic               mismatch;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_tc;

    settle_counter #(
        .WIDTH (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (LOAD_VAL),
        .tc       (cnt_tc)
    );

    assign last_vec = (idx_q == LAST_IDX);
    assign mismatch = (out != exp_q[idx_q]);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        check   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = FIRST_ST;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (cnt_tc) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                busy  = 1'b1;
                check = 1'b1;
                state_d = last_vec ? DONE : FIRST_ST;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = FIRST_ST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_load = accept || (check && !last_vec);
    assign cnt_en   = (state_q == SETTLE);

    // At most four mismatches can occur, so the guard only documents the ceiling.
    always_comb begin
        err_next = err_count;
        if (check && mismatch && (err_count < ERR_W'(NUM_VECTORS))) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            exp_q     <= '0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q     <= '0;
                exp_q     <= expected;
                pass      <= 1'b0;
                fail_mask <= '0;
                err_count <= '0;
            end else if (check) begin
                err_count <= err_next;
                if (mismatch) begin
                    fail_mask[idx_q] <= 1'b1;
                end
                if (last_vec) begin
                    pass <= (err_next == '0);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign a = idx_q[1];
    assign b = idx_q[0];

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: table of gate models vs golden tables,
// plus hand sequences for held start, mid-pass reset and SETTLE_CYCLES=1.
module tb_gate_tt_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] expected;
    logic       out;
    logic       a, b, busy, done, pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;
    int         gate_mode;

    logic       start1;
    logic [3:0] expected1;
    logic       out1;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] fail_mask1;
    logic [2:0] err_count1;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0] expv;
        int         mode;
        logic       exp_pass;
        logic [3:0] exp_mask;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl [5];

    gate_tt_checker #(.SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .expected  (expected),
        .out       (out),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .err_count (err_count)
    );

    gate_tt_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .expected  (expected1),
        .out       (out1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .fail_mask (fail_mask1),
        .err_count (err_count1)
    );

    // Gate models: 0 NOR, 1 stuck-at-0, 2 OR, 3 AND.
    always_comb begin
        case (gate_mode)
            0:       out = ~(a | b);
            1:       out = 1'b0;
            2:       out = a | b;
            default: out = a & b;
        endcase
    end
    assign out1 = ~(a1 | b1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input vec_t v);
        int seq_bad;
        expected  = v.expv;
        gate_mode = v.mode;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        expected = ~v.expv;
        chk("accept_busy", busy, 1);
        chk("accept_ab", {a, b}, 0);
        chk("accept_clear", {pass, fail_mask, err_count}, 0);
        seq_bad = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if ({a, b} != 2'(k / 2) || !busy || done) seq_bad++;
        end
        chk("vector_seq", seq_bad, 0);
        tick();
        chk("done_at_8", {done, busy}, 2'b10);
        chk("pass", pass, v.exp_pass);
        chk("fail_mask", fail_mask, v.exp_mask);
        chk("err_count", err_count, v.exp_err);
        tick();
        tick();
        chk("hold_ab", {a, b, done, busy}, 4'b1100);
        chk("hold_results", {pass, fail_mask, err_count},
            {v.exp_pass, v.exp_mask, v.exp_err});
    endtask

    initial begin
        int seq_bad;
        int done_seen;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        start1    = 1'b0;
        expected  = 4'b0001;
        expected1 = 4'b0001;
        gate_mode = 0;

        tbl[0] = '{4'b0001, 0, 1'b1, 4'b0000, 3'd0};
        tbl[1] = '{4'b0001, 1, 1'b0, 4'b0001, 3'd1};
        tbl[2] = '{4'b0001, 2, 1'b0, 4'b1111, 3'd4};
        tbl[3] = '{4'b0110, 2, 1'b0, 4'b1000, 3'd1};
        tbl[4] = '{4'b1000, 3, 1'b1, 4'b0000, 3'd0};

        #12;
        chk("reset_outputs", {a, b, busy, done, pass, fail_mask, err_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_pass(tbl[i]);
        end

        // Start held high: no restart mid-pass, back-to-back pass from DONE.
        gate_mode = 0;
        expected  = 4'b0001;
        start     = 1'b1;
        tick();
        seq_bad = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if ({a, b} != 2'(k / 2) || !busy || done) seq_bad++;
        end
        chk("busy_start_seq", seq_bad, 0);
        tick();
        chk("busy_start_done1", {done, busy}, 2'b10);
        tick();
        start = 1'b0;
        chk("busy_start_restart", {a, b, busy, done}, 4'b0010);
        seq_bad = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done) seq_bad++;
        end
        chk("busy_start_no_early_done", seq_bad, 0);
        tick();
        chk("busy_start_done2", {done, pass}, 2'b11);
        tick();

        // Reset while vector 10 is on the gate, with two mismatches already logged.
        gate_mode = 2;
        expected  = 4'b0001;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("midreset_pre_ab", {a, b}, 2'b10);
        chk("midreset_pre_err", err_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", {a, b, busy, done, pass, fail_mask, err_count}, 0);
        #1 rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        chk("midreset_no_done", done_seen, 0);
        run_pass(tbl[0]);

        // SETTLE_CYCLES=1 instance: one vector per edge.
        expected1 = 4'b0001;
        start1    = 1'b1;
        tick();
        start1    = 1'b0;
        expected1 = 4'b1110;
        chk("s1_accept", {a1, b1, busy1}, 3'b001);
        seq_bad = 0;
        for (int k = 1; k < 4; k++) begin
            tick();
            if ({a1, b1} != 2'(k) || !busy1 || done1) seq_bad++;
        end
        chk("s1_vector_seq", seq_bad, 0);
        tick();
        chk("s1_done_at_4", {done1, busy1}, 2'b10);
        chk("s1_results", {pass1, fail_mask1, err_count1}, {1'b1, 4'b0000, 3'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of clock cycles each input vector is held before out is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to run one exhaustive truth-table pass.
REQ-005 SHALL have port expected  input  4  golden truth table; bit i is the expected out for {a,b} = i.
REQ-006 SHALL have port out  input  1  response from the 2-input gate under test.
REQ-007 SHALL have port a  output  1  gate input a, MSB of the vector index, registered.
REQ-008 SHALL have port b  output  1  gate input b, LSB of the vector index, registered.
REQ-009 SHALL have port busy  output  1  high while a pass is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a pass completes.
REQ-011 SHALL have port pass  output  1  high when the last completed pass had zero mismatches.
REQ-012 SHALL have port fail_mask  output  4  bit i set when vector i mismatched in the last pass.
REQ-013 SHALL have port err_count  output  3  number of mismatches in the last pass, 0..4.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, CHECK and DONE.
REQ-015 SHALL accept start only when busy is 0, i.e. in IDLE or DONE; start while busy is 1 SHALL be ignored.
REQ-016 On the edge that accepts start, the block SHALL:
- drive {a,b} = 00
- clear fail_mask, err_count and pass
- latch expected into an internal register, so later changes to the expected input do not affect the running pass
- set busy and enter SETTLE.
REQ-017 SETTLE SHALL hold {a,b} constant for SETTLE_CYCLES cycles, counted from the edge that drove the vector.
REQ-018 CHECK SHALL sample out on the edge exactly SETTLE_CYCLES edges after the vector was driven, compare it with latched expected[index], and on mismatch set fail_mask[index] and increment err_count.
REQ-019 On the CHECK edge, if index < 3, the block SHALL drive index+1 on {a,b} and return to SETTLE; a new vector therefore appears every SETTLE_CYCLES cycles.
REQ-020 On the CHECK edge for index 3, the block SHALL:
- include the index-3 result in fail_mask and err_count
- set pass = (final err_count == 0)
- enter DONE with done = 1 and busy = 0.
REQ-021 The DONE state SHALL last exactly one cycle and then go to IDLE.
REQ-022 A start accepted in DONE SHALL begin a new pass at once, with no IDLE cycle in between.
REQ-023 Total latency SHALL be 4*SETTLE_CYCLES edges from the start-accept edge to the done edge; with the default, done rises 8 edges after start is accepted.
REQ-024 After a pass and until the next accepted start, {a,b} SHALL stay at 11 and pass, fail_mask and err_count SHALL hold their values.
REQ-025 err_count SHALL be 3 bits wide, SHALL saturate by construction at 4, and SHALL never wrap.

Reset
REQ-026 rst high SHALL immediately, without waiting for clk, force: state IDLE, a=0, b=0, busy=0, done=0, pass=0, fail_mask=0000, err_count=000, index=0, settle counter=0.
REQ-027 Reset asserted mid-pass SHALL abort the pass with no done pulse; results return to their reset values.
REQ-028 The first start after rst deasserts SHALL be honoured on the next edge.

Structure
REQ-029 The state encoding and the vector count of 4 SHALL be defined in a shared package, gate_test_pkg.
REQ-030 The settle timer SHALL be a separate sub-module, settle_counter, with load, a terminal-count output and a width sized from SETTLE_CYCLES.
REQ-031 The FSM, index register and result registers SHALL remain in gate_tt_checker.

Verification
REQ-032 The bench SHALL cover these scenarios, with the default parameter unless stated:
- NOR scenario: expected=0001, out driven by a correct NOR of a and b -> done 8 edges after start, pass=1, fail_mask=0000, err_count=0, vector sequence 00,01,10,11 each held 2 cycles.
- Stuck-at-0 scenario: expected=0001, out tied to 0 -> pass=0, fail_mask=0001, err_count=1.
- Inverted scenario: expected=0001, out = OR of a and b -> fail_mask=1111, err_count=4, pass=0.
- Busy-start scenario: start held high through the whole pass -> no restart before done; a second pass begins on the done edge, and the next done follows 8 edges later.
- Mid-pass reset scenario: rst pulsed while {a,b}=10 -> outputs return to reset values at once; no done pulse; a fresh start then completes normally.
- SETTLE_CYCLES=1 scenario: expected=0001, correct NOR gate -> done 4 edges after start, pass=1.
